// File: rtl/sdram_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-request SDRAM controller.
// Data port is preferred; a starve counter guarantees the instruction port a grant periodically.
module sdram_arbiter #(
  parameter int STARVE_LIMIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [23:0] i_addr,
  output logic [15:0] i_data,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [23:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_ack,
  output logic [23:0] m_addr,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata,
  output logic        m_read_req,
  output logic        m_write_req,
  input  logic        m_busy
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [1:0]    state_q,   state_d;
  logic [SW-1:0] starve_q,  starve_d;
  logic [2:0]    retry_q,   retry_d;
  logic          owner_q,   owner_d;   // 1 = instruction port owns the transaction
  logic          we_q,      we_d;
  logic [23:0]   addr_q,    addr_d;
  logic [15:0]   wdata_q,   wdata_d;
  logic [15:0]   i_data_q,  i_data_d;
  logic [15:0]   d_rdata_q, d_rdata_d;
  logic          i_ack_q,   i_ack_d;
  logic          d_ack_q,   d_ack_d;
  logic          grant_d_s, grant_i_s;

  // Next-state, grant and completion logic.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    retry_d   = retry_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_data_d  = i_data_q;
    d_rdata_d = d_rdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    grant_d_s = 1'b0;
    grant_i_s = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The ack cycle is skipped so a requester still holding req is not served twice.
        if (!i_ack_q && !d_ack_q && (d_req || i_req)) begin
          if (d_req && !(i_req && (starve_q == STARVE_MAX))) begin
            grant_d_s = 1'b1;
            addr_d    = d_addr;
            wdata_d   = d_wdata;
            we_d      = d_we;
            owner_d   = 1'b0;
          end else begin
            grant_i_s = 1'b1;
            addr_d    = i_addr;
            wdata_d   = 16'h0000;
            we_d      = 1'b0;
            owner_d   = 1'b1;
          end
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (!m_busy) begin
          state_d = S_WAIT_BUSY;
          retry_d = 3'd0;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT_BUSY: begin
        if (m_busy) begin
          state_d = S_WAIT_DONE;
        end else if (retry_q == 3'd7) begin
          state_d = S_ISSUE;
        end else begin
          retry_d = retry_q + 3'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!m_busy) begin
          if (owner_q) begin
            i_ack_d  = 1'b1;
            i_data_d = m_rdata;
          end else begin
            d_ack_d = 1'b1;
            if (!we_q) begin
              d_rdata_d = m_rdata;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!i_req) begin
      starve_d = {SW{1'b0}};
    end else if (grant_i_s) begin
      starve_d = {SW{1'b0}};
    end else if (grant_d_s && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + {{(SW-1){1'b0}}, 1'b1};
    end else begin
      starve_d = starve_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      starve_q  <= {SW{1'b0}};
      retry_q   <= 3'd0;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 24'h000000;
      wdata_q   <= 16'h0000;
      i_data_q  <= 16'h0000;
      d_rdata_q <= 16'h0000;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      retry_q   <= retry_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_data_q  <= i_data_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
    end
  end

  // Strobes depend on the live m_busy so a busy controller never sees a request.
  assign m_read_req  = (state_q == S_ISSUE) && !m_busy && !we_q;
  assign m_write_req = (state_q == S_ISSUE) && !m_busy &&  we_q;
  assign m_addr      = addr_q;
  assign m_wdata     = wdata_q;
  assign i_data      = i_data_q;
  assign d_rdata     = d_rdata_q;
  assign i_ack       = i_ack_q;
  assign d_ack       = d_ack_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: directed stimulus pushes expected acks,
// a monitor pops and compares them, and a small controller model answers strobes.
module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [23:0] i_addr = 24'h0;
  logic [15:0] i_data;
  logic        i_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [23:0] d_addr = 24'h0;
  logic [15:0] d_wdata = 16'h0;
  logic [15:0] d_rdata;
  logic        d_ack;
  logic [23:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata = 16'h0;
  logic        m_read_req, m_write_req;
  logic        force_busy = 1'b0;
  logic        model_busy = 1'b0;
  wire         m_busy = force_busy | model_busy;

  always #5 clk = ~clk;

  sdram_arbiter #(.STARVE_LIMIT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .m_read_req(m_read_req), .m_write_req(m_write_req), .m_busy(m_busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: one entry per expected ack, in order.
  typedef struct { logic is_i; logic [15:0] data; } exp_t;
  exp_t sbq[$];
  int   ack_total = 0;
  int   last_ack_cyc = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (i_ack || d_ack) begin
        ack_total++;
        last_ack_cyc = cyc;
        chk("ack_one_hot", {31'd0, i_ack & d_ack}, 32'd0);
        chk("ack_expected", {31'd0, sbq.size() > 0}, 32'd1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("ack_port", {31'd0, i_ack}, {31'd0, e.is_i});
          chk("ack_data", {16'd0, (i_ack ? i_data : d_rdata)}, {16'd0, e.data});
        end
      end
    end
  end

  // Controller model: accepts a strobe, raises busy for busy_len cycles, optionally ignores strobes.
  logic [15:0] mem [logic [23:0]];
  int          strobes = 0;
  int          strobe_cyc[$];
  logic [23:0] last_addr = 24'h0;
  logic [15:0] last_wdata = 16'h0;
  logic        last_we = 1'b0;
  logic        m_stb = 1'b0;
  int          busy_len = 2;
  int          ignore_left = 0;
  int          busy_left = 0;

  initial begin
    forever begin
      @(negedge clk);
      m_stb = m_read_req | m_write_req;
      if (m_stb) begin
        strobes++;
        strobe_cyc.push_back(cyc);
        last_addr  = m_addr;
        last_wdata = m_wdata;
        last_we    = m_write_req;
        chk("strobe_one_hot", {31'd0, m_read_req & m_write_req}, 32'd0);
      end
      @(posedge clk);
      #1;
      if (m_stb && ignore_left > 0) begin
        ignore_left--;
      end else if (m_stb) begin
        busy_left = busy_len;
        if (last_we) mem[last_addr] = last_wdata;
        else m_rdata = mem.exists(last_addr) ? mem[last_addr] : 16'h0000;
      end else if (busy_left > 0) begin
        busy_left--;
      end
      model_busy = (busy_left > 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acks(input int target, input int limit, input string name);
    int n = 0;
    while (ack_total < target && n < limit) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk(name, {31'd0, ack_total >= target}, 32'd1);
  endtask

  task automatic push(input logic is_i, input logic [15:0] data);
    exp_t e;
    e.is_i = is_i;
    e.data = data;
    sbq.push_back(e);
  endtask

  int s0, n0, base, t0;

  initial begin
    mem[24'h400010] = 16'h1234;
    mem[24'h000010] = 16'hD00D;
    mem[24'h000020] = 16'h1111;
    mem[24'h000030] = 16'hA5C3;
    mem[24'h000040] = 16'h0BAD;

    repeat (3) tick();
    @(negedge clk);
    chk("rst_acks",    {30'd0, i_ack, d_ack}, 32'd0);
    chk("rst_strobes", {30'd0, m_read_req, m_write_req}, 32'd0);
    chk("rst_data",    {i_data, d_rdata}, 32'd0);
    chk("rst_maddr",   {8'd0, m_addr}, 32'd0);
    chk("rst_mwdata",  {16'd0, m_wdata}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single write; inputs are scrambled and req dropped while in flight.
    busy_len = 3; s0 = strobes; base = ack_total;
    push(1'b0, 16'h0000);
    d_we = 1'b1; d_addr = 24'h000123; d_wdata = 16'hBEEF; d_req = 1'b1;
    repeat (3) tick();
    d_addr = 24'hFFFFFF; d_wdata = 16'h0000; d_we = 1'b0; d_req = 1'b0;
    wait_acks(base + 1, 40, "wr_timeout");
    chk("wr_strobes", strobes - s0, 32'd1);
    chk("wr_we",      {31'd0, last_we}, 32'd1);
    chk("wr_addr",    {8'd0, last_addr}, 32'h000123);
    chk("wr_wdata",   {16'd0, last_wdata}, 32'hBEEF);
    chk("wr_maddr_hold", {8'd0, m_addr}, 32'h000123);

    // Instruction read: req cycle through ack cycle spans 4 + busy cycles.
    busy_len = 2; base = ack_total;
    push(1'b1, 16'h1234);
    i_addr = 24'h400010; i_req = 1'b1; t0 = cyc;
    wait_acks(base + 1, 40, "ir_timeout");
    i_req = 1'b0;
    chk("ir_latency", last_ack_cyc - t0, busy_len + 3);

    // Data read of the earlier write, then a write that must leave d_rdata alone.
    base = ack_total;
    push(1'b0, 16'hBEEF);
    d_we = 1'b0; d_addr = 24'h000123; d_req = 1'b1;
    wait_acks(base + 1, 40, "dr_timeout");
    push(1'b0, 16'hBEEF);
    d_we = 1'b1; d_addr = 24'h000124; d_wdata = 16'h0F0F;
    wait_acks(base + 2, 40, "dw_timeout");
    d_req = 1'b0;
    chk("i_data_hold", {16'd0, i_data}, 32'h1234);
    chk("d_rdata_hold", {16'd0, d_rdata}, 32'hBEEF);

    // Both ports held: STARVE_LIMIT=2 gives D,D,I,D,D,I.
    busy_len = 1; base = ack_total;
    push(1'b0, 16'hD00D); push(1'b0, 16'hD00D); push(1'b1, 16'h1111);
    push(1'b0, 16'hD00D); push(1'b0, 16'hD00D); push(1'b1, 16'h1111);
    d_we = 1'b0; d_addr = 24'h000010; i_addr = 24'h000020;
    d_req = 1'b1; i_req = 1'b1;
    wait_acks(base + 6, 200, "starve_timeout");
    d_req = 1'b0; i_req = 1'b0;
    tick();

    // Controller busy for 20 cycles before issue: no strobe until it frees.
    force_busy = 1'b1; s0 = strobes; base = ack_total;
    push(1'b0, 16'hD00D);
    d_we = 1'b1; d_addr = 24'h000055; d_wdata = 16'h1357; d_req = 1'b1;
    repeat (20) tick();
    chk("busy_hold_nostrobe", strobes - s0, 32'd0);
    force_busy = 1'b0;
    wait_acks(base + 1, 40, "busy_timeout");
    d_req = 1'b0;
    chk("busy_one_strobe", strobes - s0, 32'd1);

    // First strobe ignored: retry after 8 idle WAIT_BUSY cycles.
    ignore_left = 1; s0 = strobes; n0 = strobe_cyc.size(); base = ack_total;
    push(1'b0, 16'hA5C3);
    d_we = 1'b0; d_addr = 24'h000030; d_req = 1'b1;
    wait_acks(base + 1, 60, "retry_timeout");
    d_req = 1'b0;
    chk("retry_strobes", strobes - s0, 32'd2);
    if (strobe_cyc.size() >= n0 + 2) begin
      chk("retry_gap", strobe_cyc[n0+1] - strobe_cyc[n0], 32'd9);
      chk("retry_ack_after", {31'd0, last_ack_cyc > strobe_cyc[n0+1]}, 32'd1);
    end else begin
      chk("retry_second_strobe", strobe_cyc.size() - n0, 32'd2);
    end

    // Reset during WAIT_DONE: no ack, outputs cleared, held req served after release.
    busy_len = 10; s0 = strobes;
    d_we = 1'b0; d_addr = 24'h000040; d_req = 1'b1;
    t0 = 0;
    while (strobes == s0 && t0 < 20) begin tick(); t0++; end
    chk("rst_mid_strobe", {31'd0, strobes > s0}, 32'd1);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_mid_acks", {30'd0, i_ack, d_ack}, 32'd0);
    chk("rst_mid_data", {i_data, d_rdata}, 32'd0);
    chk("rst_mid_maddr", {8'd0, m_addr}, 32'd0);
    chk("rst_mid_mwdata", {16'd0, m_wdata}, 32'd0);
    tick();
    base = ack_total;
    push(1'b0, 16'h0BAD);
    rst_n = 1'b1;
    wait_acks(base + 1, 80, "rst_reserve_timeout");
    d_req = 1'b0;
    chk("rst_reserve_strobes", {31'd0, (strobes - s0) >= 2}, 32'd1);
    repeat (3) tick();
    chk("sb_drained", sbq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
